// File: rtl/deser_pkg.sv
// Shared constants and helpers for the framed serial deserializer.
package deser_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_SHORT  = 2'b01,
    ERR_LONG   = 2'b10,
    ERR_PARITY = 2'b11
  } err_code_e;

  // Serial frame width: payload plus an optional trailing parity bit.
  function automatic int fw(input int addr_w, input int data_w, input int parity);
    return addr_w + data_w + ((parity != PAR_NONE) ? 1 : 0);
  endfunction

endpackage

// File: rtl/deser_frame_check.sv
// Classifies a frame at its load edge from the bit count, overrun and parity.
module deser_frame_check
  import deser_pkg::*;
#(
  parameter int FW     = 19,
  parameter int PARITY = 0,
  parameter int CW     = 5
) (
  input  logic [CW-1:0] count,
  input  logic          overrun,
  input  logic          par_acc,
  input  logic          bit_in,
  output logic          good,
  output logic [1:0]    err_code
);

  logic par_all;

  always_comb begin
    good     = 1'b0;
    err_code = ERR_NONE;
    par_all  = par_acc ^ bit_in;
    // count excludes the load bit itself, so total = count + 1
    if (overrun || (count >= CW'(FW))) begin
      err_code = ERR_LONG;
    end else if (count < CW'(FW - 1)) begin
      err_code = ERR_SHORT;
    end else if ((PARITY == PAR_EVEN) && par_all) begin
      err_code = ERR_PARITY;
    end else if ((PARITY == PAR_ODD) && !par_all) begin
      err_code = ERR_PARITY;
    end else begin
      good = 1'b1;
    end
  end

endmodule

// File: rtl/deserializer_framed.sv
// Framed serial-to-parallel receiver: shifts bits on RX_CLK, validates the frame
// on RX_LOAD and presents a held address/data pair or an error pulse with code.
module deserializer_framed
  import deser_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 16,
  parameter int PARITY    = 0,
  parameter int MSB_FIRST = 1,
  parameter int ERRCNT_W  = 8
) (
  input  logic                RX_CLK,
  input  logic                RST,
  input  logic                RX_DATA,
  input  logic                RX_LOAD,
  input  logic                RX_STOP,
  output logic [ADDR_W-1:0]   P_ADDR,
  output logic [DATA_W-1:0]   P_DATA,
  output logic                P_ENA,
  output logic                P_ERR,
  output logic [1:0]          P_ERR_CODE,
  output logic [ERRCNT_W-1:0] ERR_CNT
);

  localparam int PL  = ADDR_W + DATA_W;
  localparam int FW  = fw(ADDR_W, DATA_W, PARITY);
  localparam int CW  = $clog2(FW + 1);
  localparam int SRW = FW - 1;

  logic [SRW-1:0]      sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovr_q, ovr_d;
  logic                par_q, par_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ena_q, ena_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic [ERRCNT_W-1:0] ecnt_q, ecnt_d;

  logic [PL-1:0] frame;
  logic [PL-1:0] payload;
  logic          chk_good;
  logic [1:0]    chk_code;

  // frame[PL-1] is always b0; with parity the load bit is the parity bit.
  generate
    if (PARITY != PAR_NONE) begin : g_par_frame
      assign frame = sr_q;
    end else begin : g_raw_frame
      assign frame = {sr_q, RX_DATA};
    end

    if (MSB_FIRST != 0) begin : g_msb_first
      assign payload = frame;
    end else begin : g_lsb_first
      for (genvar gi = 0; gi < PL; gi++) begin : g_rev
        assign payload[gi] = frame[PL-1-gi];
      end
    end
  endgenerate

  deser_frame_check #(
    .FW     (FW),
    .PARITY (PARITY),
    .CW     (CW)
  ) u_check (
    .count    (cnt_q),
    .overrun  (ovr_q),
    .par_acc  (par_q),
    .bit_in   (RX_DATA),
    .good     (chk_good),
    .err_code (chk_code)
  );

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    par_d  = par_q;
    addr_d = addr_q;
    data_d = data_q;
    ena_d  = 1'b0;
    err_d  = 1'b0;
    code_d = code_q;
    ecnt_d = ecnt_q;
    if (RX_STOP) begin
      cnt_d = '0;
      ovr_d = 1'b0;
      par_d = 1'b0;
    end else begin
      sr_d = SRW'({sr_q, RX_DATA});
      if (RX_LOAD) begin
        cnt_d = '0;
        ovr_d = 1'b0;
        par_d = 1'b0;
        if (chk_good) begin
          ena_d  = 1'b1;
          addr_d = payload[PL-1 -: ADDR_W];
          data_d = payload[DATA_W-1:0];
        end else begin
          err_d  = 1'b1;
          code_d = chk_code;
          if (ecnt_q != '1) ecnt_d = ecnt_q + ERRCNT_W'(1);
        end
      end else begin
        par_d = par_q ^ RX_DATA;
        if (cnt_q == CW'(FW)) ovr_d = 1'b1;
        else                  cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (RST) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      par_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ena_q  <= 1'b0;
      err_q  <= 1'b0;
      code_q <= '0;
      ecnt_q <= '0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      par_q  <= par_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ena_q  <= ena_d;
      err_q  <= err_d;
      code_q <= code_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign P_ADDR     = addr_q;
  assign P_DATA     = data_q;
  assign P_ENA      = ena_q;
  assign P_ERR      = err_q;
  assign P_ERR_CODE = code_q;
  assign ERR_CNT    = ecnt_q;

endmodule

// File: tb/tb_deserializer_framed.sv
// Three differently configured receivers share one serial stream; a bit-list
// model judges each frame by length/parity rules and predicts every output.
module tb_deserializer_framed;

  localparam int NI = 3;
  localparam int AW  [NI] = '{3, 3, 2};
  localparam int DW  [NI] = '{16, 16, 5};
  localparam int PAR [NI] = '{0, 1, 2};
  localparam int MSB [NI] = '{1, 0, 1};
  localparam int CWE [NI] = '{8, 8, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rx_rst, rx_data, rx_load, rx_stop;

  logic [2:0]  u0_addr; logic [15:0] u0_data; logic u0_ena, u0_err; logic [1:0] u0_code; logic [7:0] u0_cnt;
  logic [2:0]  u1_addr; logic [15:0] u1_data; logic u1_ena, u1_err; logic [1:0] u1_code; logic [7:0] u1_cnt;
  logic [1:0]  u2_addr; logic [4:0]  u2_data; logic u2_ena, u2_err; logic [1:0] u2_code; logic [1:0] u2_cnt;

  deserializer_framed #(.ADDR_W(3), .DATA_W(16), .PARITY(0), .MSB_FIRST(1), .ERRCNT_W(8)) u0 (
    .RX_CLK(clk), .RST(rx_rst), .RX_DATA(rx_data), .RX_LOAD(rx_load), .RX_STOP(rx_stop),
    .P_ADDR(u0_addr), .P_DATA(u0_data), .P_ENA(u0_ena), .P_ERR(u0_err),
    .P_ERR_CODE(u0_code), .ERR_CNT(u0_cnt));
  deserializer_framed #(.ADDR_W(3), .DATA_W(16), .PARITY(1), .MSB_FIRST(0), .ERRCNT_W(8)) u1 (
    .RX_CLK(clk), .RST(rx_rst), .RX_DATA(rx_data), .RX_LOAD(rx_load), .RX_STOP(rx_stop),
    .P_ADDR(u1_addr), .P_DATA(u1_data), .P_ENA(u1_ena), .P_ERR(u1_err),
    .P_ERR_CODE(u1_code), .ERR_CNT(u1_cnt));
  deserializer_framed #(.ADDR_W(2), .DATA_W(5), .PARITY(2), .MSB_FIRST(1), .ERRCNT_W(2)) u2 (
    .RX_CLK(clk), .RST(rx_rst), .RX_DATA(rx_data), .RX_LOAD(rx_load), .RX_STOP(rx_stop),
    .P_ADDR(u2_addr), .P_DATA(u2_data), .P_ENA(u2_ena), .P_ERR(u2_err),
    .P_ERR_CODE(u2_code), .ERR_CNT(u2_cnt));

  logic [63:0] g_addr [NI], g_data [NI], g_ena [NI], g_err [NI], g_code [NI], g_cnt [NI];
  assign g_addr[0] = 64'(u0_addr); assign g_data[0] = 64'(u0_data); assign g_ena[0] = 64'(u0_ena);
  assign g_err[0]  = 64'(u0_err);  assign g_code[0] = 64'(u0_code); assign g_cnt[0] = 64'(u0_cnt);
  assign g_addr[1] = 64'(u1_addr); assign g_data[1] = 64'(u1_data); assign g_ena[1] = 64'(u1_ena);
  assign g_err[1]  = 64'(u1_err);  assign g_code[1] = 64'(u1_code); assign g_cnt[1] = 64'(u1_cnt);
  assign g_addr[2] = 64'(u2_addr); assign g_data[2] = 64'(u2_data); assign g_ena[2] = 64'(u2_ena);
  assign g_err[2]  = 64'(u2_err);  assign g_code[2] = 64'(u2_code); assign g_cnt[2] = 64'(u2_cnt);

  // Model state: bits received since the last clear, and predicted outputs.
  logic [63:0] mv [NI];
  int          mlen [NI];
  logic [63:0] e_addr [NI], e_data [NI], e_ena [NI], e_err [NI], e_code [NI], e_cnt [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic judge(input int i);
    int fwi, pli;
    logic [1:0] code;
    logic x;
    logic [63:0] pay;
    pli  = AW[i] + DW[i];
    fwi  = pli + ((PAR[i] != 0) ? 1 : 0);
    code = 2'b00;
    if (mlen[i] > fwi) code = 2'b10;
    else if (mlen[i] < fwi) code = 2'b01;
    else if (PAR[i] != 0) begin
      x = ^(mv[i] & ((64'd1 << fwi) - 64'd1));
      if ((PAR[i] == 1 && x) || (PAR[i] == 2 && !x)) code = 2'b11;
    end
    if (code != 2'b00) begin
      e_err[i]  = 64'd1;
      e_code[i] = 64'(code);
      if (e_cnt[i] < (64'd1 << CWE[i]) - 64'd1) e_cnt[i] = e_cnt[i] + 64'd1;
    end else begin
      pay = 64'd0;
      for (int k = 0; k < pli; k++) begin
        if (MSB[i] != 0) pay[pli-1-k] = mv[i][k];
        else             pay[k]       = mv[i][k];
      end
      e_ena[i]  = 64'd1;
      e_addr[i] = pay >> DW[i];
      e_data[i] = pay & ((64'd1 << DW[i]) - 64'd1);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (rx_rst) begin
        mlen[i] = 0; mv[i] = '0;
        e_addr[i] = '0; e_data[i] = '0; e_ena[i] = '0;
        e_err[i] = '0; e_code[i] = '0; e_cnt[i] = '0;
      end else begin
        e_ena[i] = '0;
        e_err[i] = '0;
        if (rx_stop) begin
          mlen[i] = 0; mv[i] = '0;
        end else begin
          if (mlen[i] < 64) mv[i][mlen[i]] = rx_data;
          mlen[i]++;
          if (rx_load) begin
            judge(i);
            mlen[i] = 0; mv[i] = '0;
          end
        end
      end
    end
  endtask

  // One clock edge: DUTs sample current inputs, model follows, outputs compared.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("u%0d.P_ENA", i),      g_ena[i],  e_ena[i]);
      check_eq($sformatf("u%0d.P_ERR", i),      g_err[i],  e_err[i]);
      check_eq($sformatf("u%0d.P_ERR_CODE", i), g_code[i], e_code[i]);
      check_eq($sformatf("u%0d.P_ADDR", i),     g_addr[i], e_addr[i]);
      check_eq($sformatf("u%0d.P_DATA", i),     g_data[i], e_data[i]);
      check_eq($sformatf("u%0d.ERR_CNT", i),    g_cnt[i],  e_cnt[i]);
    end
  endtask

  // Sends n bits, bit k = s[k], optionally with RX_LOAD on the last one.
  task automatic send_seq(input logic [63:0] s, input int n, input bit load_last);
    for (int k = 0; k < n; k++) begin
      rx_data = s[k];
      rx_load = load_last && (k == n - 1);
      rx_stop = 1'b0;
      step();
    end
    rx_load = 1'b0;
    $display("tx bits=%0d load=%0d seq=%0h", n, load_last, s);
  endtask

  function automatic logic [63:0] msb_seq(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = v[n-1-k];
    return r;
  endfunction

  task automatic stop_cycle();
    rx_stop = 1'b1; rx_load = 1'b0; rx_data = 1'b0;
    step();
    rx_stop = 1'b0;
  endtask

  function automatic int pick_len();
    case ($urandom_range(0, 7))
      0: return 19;
      1: return 20;
      2: return 8;
      3: return 18;
      4: return 21;
      5: return 7;
      6: return 9;
      default: return int'($urandom_range(1, 24));
    endcase
  endfunction

  initial begin
    logic [63:0] s;
    logic [18:0] p;
    int run, tgt;
    for (int i = 0; i < NI; i++) begin
      mlen[i] = 0; mv[i] = '0;
      e_addr[i] = '0; e_data[i] = '0; e_ena[i] = '0;
      e_err[i] = '0; e_code[i] = '0; e_cnt[i] = '0;
    end
    rx_rst = 1'b1; rx_data = 1'b0; rx_load = 1'b0; rx_stop = 1'b0;
    step();
    check_eq("reset.u0_ena", g_ena[0], 64'd0);
    check_eq("reset.u0_cnt", g_cnt[0], 64'd0);
    rx_rst = 1'b0;

    // Default good frame, MSB first
    send_seq(msb_seq({45'd0, 3'b101, 16'hA5C3}, 19), 19, 1'b1);
    check_eq("good.u0_ena",  g_ena[0],  64'd1);
    check_eq("good.u0_addr", g_addr[0], 64'd5);
    check_eq("good.u0_data", g_data[0], 64'hA5C3);
    check_eq("good.u0_err",  g_err[0],  64'd0);
    stop_cycle();
    check_eq("hold.u0_ena",  g_ena[0],  64'd0);
    check_eq("hold.u0_data", g_data[0], 64'hA5C3);

    // Short then long frames
    send_seq(64'h2AAAA, 18, 1'b1);
    check_eq("short.u0_err",  g_err[0],  64'd1);
    check_eq("short.u0_code", g_code[0], 64'd1);
    check_eq("short.u0_cnt",  g_cnt[0],  64'd1);
    check_eq("short.u0_data", g_data[0], 64'hA5C3);
    send_seq(64'h15555, 21, 1'b1);
    check_eq("long.u0_code", g_code[0], 64'd2);
    check_eq("long.u0_cnt",  g_cnt[0],  64'd2);

    // Even parity, LSB first on u1
    p = {3'b011, 16'h0001};
    s = 64'(p);
    s[19] = ^p;
    send_seq(s, 20, 1'b1);
    check_eq("par.u1_ena",  g_ena[1],  64'd1);
    check_eq("par.u1_addr", g_addr[1], 64'd3);
    check_eq("par.u1_data", g_data[1], 64'd1);
    s[19] = ~s[19];
    send_seq(s, 20, 1'b1);
    check_eq("parbad.u1_err",  g_err[1],  64'd1);
    check_eq("parbad.u1_code", g_code[1], 64'd3);

    // Abort mid-frame, then a clean frame; then LOAD with STOP
    send_seq(64'h3FF, 10, 1'b0);
    stop_cycle();
    send_seq(msb_seq({45'd0, 3'd2, 16'h1234}, 19), 19, 1'b1);
    check_eq("abort.u0_ena",  g_ena[0],  64'd1);
    check_eq("abort.u0_addr", g_addr[0], 64'd2);
    check_eq("abort.u0_data", g_data[0], 64'h1234);
    check_eq("abort.u0_err",  g_err[0],  64'd0);
    send_seq(64'h1234, 18, 1'b0);
    rx_data = 1'b1; rx_load = 1'b1; rx_stop = 1'b1;
    step();
    rx_load = 1'b0; rx_stop = 1'b0;
    check_eq("ldstop.u0_ena", g_ena[0], 64'd0);
    check_eq("ldstop.u0_err", g_err[0], 64'd0);

    // Reset mid-frame
    send_seq(64'h55, 7, 1'b0);
    rx_rst = 1'b1;
    step();
    rx_rst = 1'b0;
    check_eq("rst.u0_addr", g_addr[0], 64'd0);
    check_eq("rst.u0_data", g_data[0], 64'd0);
    check_eq("rst.u0_code", g_code[0], 64'd0);
    check_eq("rst.u0_cnt",  g_cnt[0],  64'd0);
    send_seq(msb_seq({45'd0, 3'd7, 16'hFFFF}, 19), 19, 1'b1);
    check_eq("rst2.u0_ena",  g_ena[0],  64'd1);
    check_eq("rst2.u0_addr", g_addr[0], 64'd7);
    check_eq("rst2.u0_data", g_data[0], 64'hFFFF);

    // Saturating 2-bit error counter on u2: repeated single-edge loads
    rx_rst = 1'b1;
    step();
    rx_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rx_data = 1'b0; rx_load = 1'b1;
      step();
      check_eq($sformatf("sat%0d.u2_cnt", k), g_cnt[2], (k < 3) ? 64'(k + 1) : 64'd3);
      check_eq($sformatf("sat%0d.u2_err", k), g_err[2], 64'd1);
    end
    rx_load = 1'b0;

    // Back-to-back good frames, no gap
    stop_cycle();
    send_seq(msb_seq({45'd0, 3'd1, 16'hBEEF}, 19), 19, 1'b1);
    check_eq("b2b1.u0_ena",  g_ena[0],  64'd1);
    send_seq(msb_seq({45'd0, 3'd6, 16'h0F0F}, 19), 19, 1'b1);
    check_eq("b2b2.u0_ena",  g_ena[0],  64'd1);
    check_eq("b2b2.u0_data", g_data[0], 64'h0F0F);

    // Randomized stream against the model
    run = 0;
    tgt = pick_len();
    for (int c = 0; c < 2500; c++) begin
      rx_rst  = ($urandom_range(0, 199) == 0);
      rx_stop = ($urandom_range(0, 39) == 0);
      rx_data = 1'($urandom_range(0, 1));
      rx_load = (run + 1 >= tgt);
      step();
      if (rx_rst || rx_stop || rx_load) begin
        run = 0;
        tgt = pick_len();
      end else begin
        run++;
      end
    end
    rx_rst = 1'b0; rx_stop = 1'b0; rx_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
